// File: rtl/game_status_ctrl.sv
// Game session controller: start/play/invulnerable/game-over sequencing, score/health/high-score
// registers and game-over LED animation pacing. Define SCORE_BCD_EN for packed-BCD scores.
module game_status_ctrl #(
   parameter logic [3:0]  START_HEALTH  = 4'hF,
   parameter int unsigned KILL_POINTS   = 1,
   parameter int unsigned INVULN_CYCLES = 50000000,
   parameter int unsigned ANIM_DIV      = 12500000,
   parameter int unsigned ANIM_STEPS    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       kill_evt,
   input  logic       hit_evt,
   output logic [7:0] score,
   output logic [3:0] health,
   output logic [7:0] high_score,
   output logic [1:0] state,
   output logic       anim_step,
   output logic       anim_clear,
   output logic       new_high,
   output logic       game_over
);

   localparam int IW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
   localparam int AW = $clog2(ANIM_DIV);
   localparam int CW = $clog2(ANIM_STEPS + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_PLAY   = 2'b01,
      S_INVULN = 2'b10,
      S_OVER   = 2'b11
   } state_t;

   state_t          r_state, w_next;
   logic [7:0]      r_score, r_high;
   logic [3:0]      r_health;
   logic [IW-1:0]   r_inv_tmr;
   logic [AW-1:0]   r_anim_tmr;
   logic [CW-1:0]   r_anim_cnt;
   logic            r_anim_step, r_anim_clear, r_new_high;
   logic [7:0]      w_score_inc, w_final;
   logic            w_fatal;

`ifdef SCORE_BCD_EN
   // Decimal add with a single carry into the tens digit; KILL_POINTS <= 9 bounds the carry to one.
   logic [4:0] w_lo_sum;
   always_comb begin
      w_lo_sum    = {1'b0, r_score[3:0]} + 5'(KILL_POINTS);
      w_score_inc = {r_score[7:4], w_lo_sum[3:0]};
      if (w_lo_sum > 5'd9) begin
         if (r_score[7:4] >= 4'd9) w_score_inc = 8'h99;
         else                      w_score_inc = {r_score[7:4] + 4'd1, 4'(w_lo_sum - 5'd10)};
      end
   end
`else
   logic [8:0] w_sum;
   assign w_sum       = {1'b0, r_score} + 9'(KILL_POINTS);
   assign w_score_inc = w_sum[8] ? 8'hFF : w_sum[7:0];
`endif

   // A kill landing on the same edge as the fatal hit counts toward the high-score compare.
   assign w_final = kill_evt ? w_score_inc : r_score;
   assign w_fatal = hit_evt && (r_health <= 4'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (start) w_next = S_PLAY;
      else begin
         case (r_state)
            S_PLAY:   if (hit_evt) w_next = w_fatal ? S_OVER : S_INVULN;
            S_INVULN: if (r_inv_tmr == '0) w_next = S_PLAY;
            default:  ;
         endcase
      end
   end

   always_comb begin
      state      = r_state;
      game_over  = (r_state == S_OVER);
      score      = r_score;
      health     = r_health;
      high_score = r_high;
      anim_step  = r_anim_step;
      anim_clear = r_anim_clear;
      new_high   = r_new_high;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_score      <= '0;
         r_health     <= START_HEALTH;
         r_high       <= '0;
         r_inv_tmr    <= '0;
         r_anim_tmr   <= '0;
         r_anim_cnt   <= '0;
         r_anim_step  <= 1'b0;
         r_anim_clear <= 1'b0;
         r_new_high   <= 1'b0;
      end else begin
         r_anim_step  <= 1'b0;
         r_anim_clear <= 1'b0;
         r_new_high   <= 1'b0;
         if (start) begin
            r_score      <= '0;
            r_health     <= START_HEALTH;
            r_inv_tmr    <= '0;
            r_anim_tmr   <= '0;
            r_anim_cnt   <= '0;
            r_anim_clear <= 1'b1;
         end else begin
            case (r_state)
               S_PLAY: begin
                  if (kill_evt) r_score <= w_score_inc;
                  if (hit_evt) begin
                     r_health <= (r_health == 4'd0) ? 4'd0 : r_health - 4'd1;
                     if (w_fatal) begin
                        r_anim_tmr <= '0;
                        r_anim_cnt <= '0;
                        if (w_final > r_high) begin
                           r_high     <= w_final;
                           r_new_high <= 1'b1;
                        end
                     end else begin
                        r_inv_tmr <= IW'(INVULN_CYCLES - 1);
                     end
                  end
               end
               S_INVULN: begin
                  if (kill_evt) r_score <= w_score_inc;
                  if (r_inv_tmr != '0) r_inv_tmr <= r_inv_tmr - 1'b1;
               end
               S_OVER: begin
                  if (r_anim_cnt < CW'(ANIM_STEPS)) begin
                     if (r_anim_tmr == AW'(ANIM_DIV - 1)) begin
                        r_anim_tmr  <= '0;
                        r_anim_cnt  <= r_anim_cnt + 1'b1;
                        r_anim_step <= 1'b1;
                     end else begin
                        r_anim_tmr <= r_anim_tmr + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
